// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data memory with byte-lane stores, wait-stated loads and optional MMIO (macro DMEM_MMIO_EN)
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] MMIO_ADDR   = 32'hFFFF_FFF0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byte_en,
    input  logic        mem_write,
    input  logic        mem_read,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        err,
    output logic [31:0] mmio_out,
    output logic        mmio_valid
);
`ifdef DMEM_MMIO_EN
    localparam bit MMIO_EN = 1'b1;
`else
    localparam bit MMIO_EN = 1'b0;
`endif
    localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES > 1 ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    logic [31:0]   mem [DEPTH_WORDS];
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          rng_q, rng_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [31:0]   mmio_out_q, mmio_out_d;
    logic          mmio_valid_q, mmio_valid_d;

    logic [AW-1:0] idx;
    logic          in_range, mmio_hit, ram_ok;
    logic          rd_req, rd_acc, wr_acc, mmio_wr, mmio_rd;
    logic [31:0]   ram_word, cap_word;
    logic          unused_addr;

    assign unused_addr = ^addr[1:0];
    assign idx         = addr[AW+1:2];
    assign in_range    = {2'b00, addr[31:2]} < 32'(DEPTH_WORDS);
    assign mmio_hit    = MMIO_EN && (addr[31:2] == MMIO_ADDR[31:2]);
    assign ram_ok      = in_range && !mmio_hit;
    assign ram_word    = ram_ok ? mem[idx] : 32'h0;
    assign cap_word    = rng_q ? mem[idx_q] : 32'h0;

    // A conflicting read is dropped and MMIO reads are zero-wait, so neither stalls
    assign rd_req  = mem_read && !mem_write && !mmio_hit;
    assign stall   = reset && WAIT_CYCLES > 0 && (state_q == S_WAIT || (state_q == S_IDLE && rd_req));
    assign rd_acc  = rd_req && state_q == S_IDLE;
    assign wr_acc  = mem_write && !stall;
    assign mmio_wr = wr_acc && mmio_hit && byte_en == 4'hF;
    assign mmio_rd = mem_read && !mem_write && mmio_hit;

    assign err_d        = (mem_write && mem_read && !stall) || (wr_acc && !mmio_hit && !in_range)
                        || (wr_acc && mmio_hit && byte_en != 4'hF) || (rd_acc && !in_range);
    assign mmio_out_d   = mmio_wr ? wdata : mmio_out_q;
    assign mmio_valid_d = mmio_wr;

    assign rdata      = mmio_rd ? mmio_out_q : (WAIT_CYCLES == 0 ? ram_word : rdata_q);
    assign err        = err_q;
    assign mmio_out   = mmio_out_q;
    assign mmio_valid = mmio_valid_q;

    // Load sequencer: latch the word index on accept, count wait states, capture the word entering DONE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rng_d   = rng_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: if (rd_acc && WAIT_CYCLES > 0) begin
                idx_d   = idx;
                rng_d   = ram_ok;
                cnt_d   = CNT_INIT;
                state_d = WAIT_CYCLES == 1 ? S_DONE : S_WAIT;
                rdata_d = WAIT_CYCLES == 1 ? ram_word : rdata_q;
            end
            S_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    rdata_d = cap_word;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control, captured-load and MMIO registers; reset aborts any load in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            rng_q        <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            mmio_out_q   <= '0;
            mmio_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            rng_q        <= rng_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            mmio_out_q   <= mmio_out_d;
            mmio_valid_q <= mmio_valid_d;
        end
    end

    // RAM byte-lane writes; contents survive reset but nothing is written while it is held
    always_ff @(posedge clk) begin
        if (reset && wr_acc && ram_ok)
            for (int i = 0; i < 4; i++)
                if (byte_en[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder against a word-array model
module tb_dmem_responder;
    localparam int WC    = 2;
    localparam int DEPTH = 1024;

    logic        clk = 0;
    logic        reset = 1;
    logic [31:0] addr = 0, wdata = 0;
    logic [3:0]  byte_en = 0;
    logic        mem_write = 0, mem_read = 0;
    logic [31:0] rdata, mmio_out;
    logic        stall, err, mmio_valid;

    int checks = 0;
    int failures = 0;
    logic [31:0] ref_mem [DEPTH];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC), .MMIO_ADDR(32'hFFFF_FFF0)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .byte_en(byte_en),
        .mem_write(mem_write), .mem_read(mem_read), .rdata(rdata), .stall(stall),
        .err(err), .mmio_out(mmio_out), .mmio_valid(mmio_valid)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        mem_write = 0;
        mem_read  = 0;
        byte_en   = 0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                            input bit exp_err, input string nm);
        addr = a; wdata = d; byte_en = be; mem_write = 1; mem_read = 0;
        #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL %s store_stall: got %b want 0", nm, stall); end
        tick;
        idle;
        checks++;
        if (err !== exp_err) begin failures++; $display("FAIL %s store_err: got %b want %b", nm, err, exp_err); end
        if (a[31:2] < DEPTH)
            for (int i = 0; i < 4; i++)
                if (be[i]) ref_mem[a[11:2]][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic do_load(input logic [31:0] a, input bit exp_err, input string nm);
        logic [31:0] exp;
        exp = (a[31:2] < DEPTH) ? ref_mem[a[11:2]] : 32'h0;
        addr = a; mem_read = 1; mem_write = 0;
        for (int k = 0; k < WC; k++) begin
            #1;
            checks++;
            if (stall !== 1'b1) begin failures++; $display("FAIL %s load_stall[%0d]: got %b want 1", nm, k, stall); end
            tick;
            if (k == 0) begin
                checks++;
                if (err !== exp_err) begin failures++; $display("FAIL %s load_err: got %b want %b", nm, err, exp_err); end
            end
        end
        #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL %s done_stall: got %b want 0", nm, stall); end
        checks++;
        if (rdata !== exp) begin failures++; $display("FAIL %s done_rdata: got %h want %h", nm, rdata, exp); end
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL %s done_err: got %b want 0", nm, err); end
        tick;
    endtask

    task automatic test_reset;
        #3 reset = 0;
        tick; tick;
        checks++;
        if ({stall, err, mmio_valid} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b want 000", {stall, err, mmio_valid}); end
        checks++;
        if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        checks++;
        if (mmio_out !== 32'h0) begin failures++; $display("FAIL reset_mmio_out: got %h want 0", mmio_out); end
        @(negedge clk) reset = 1;
        tick;
    endtask

    task automatic test_fill;
        for (int i = 0; i < 64; i++) do_store(32'(i) << 2, $urandom, 4'hF, 1'b0, "fill");
        do_store(32'h0000_0FF0, 32'hCAFE_F00D, 4'hF, 1'b0, "fill_top");
    endtask

    task automatic test_store_load;
        do_store(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, "sw");
        do_load(32'h10, 1'b0, "lw_word");
        do_store(32'h11, 32'h0000AA00, 4'b0010, 1'b0, "sb");
        do_load(32'h10, 1'b0, "lw_after_sb");
        checks++;
        if (ref_mem[4] !== 32'hDEADAAEF) begin failures++; $display("FAIL model_sb: got %h want deadaaef", ref_mem[4]); end
        do_store(32'h14, 32'h0BAD_F00D, 4'b0000, 1'b0, "be0");
        idle;
    endtask

    task automatic test_back_to_back;
        do_store(32'h14, 32'h1357_9BDF, 4'hF, 1'b0, "sw14");
        do_load(32'h10, 1'b0, "b2b_first");
        do_load(32'h14, 1'b0, "b2b_second");
        do_load(32'h18, 1'b0, "b2b_third");
        idle;
    endtask

    task automatic test_conflict;
        addr = 32'h20; wdata = 32'hA5A5_5A5A; byte_en = 4'hF; mem_write = 1; mem_read = 1;
        #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL conflict_stall: got %b want 0", stall); end
        tick;
        idle;
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL conflict_err: got %b want 1", err); end
        ref_mem[8] = 32'hA5A5_5A5A;
        tick;
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL conflict_err_pulse: got %b want 0", err); end
        do_load(32'h20, 1'b0, "conflict_wrote");
        idle;
    endtask

    task automatic test_range;
        do_load(32'h0000_4000, 1'b1, "lw_oor");
        idle;
        do_store(32'h0000_1010, 32'h7777_7777, 4'hF, 1'b1, "sw_oor");
        do_load(32'h10, 1'b0, "no_alias");
        idle;
`ifndef DMEM_MMIO_EN
        do_store(32'hFFFF_FFF0, 32'h1234_5678, 4'hF, 1'b1, "sw_mmio_off");
        checks++;
        if ({mmio_out, mmio_valid} !== 33'h0) begin failures++; $display("FAIL mmio_off: got %h/%b want 0/0", mmio_out, mmio_valid); end
        do_load(32'h0000_0FF0, 1'b0, "no_alias_top");
        idle;
`endif
    endtask

`ifdef DMEM_MMIO_EN
    task automatic test_mmio;
        addr = 32'hFFFF_FFF0; wdata = 32'h1234_5678; byte_en = 4'hF; mem_write = 1;
        tick;
        idle;
        checks++;
        if (mmio_out !== 32'h1234_5678) begin failures++; $display("FAIL mmio_out: got %h want 12345678", mmio_out); end
        checks++;
        if (mmio_valid !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL mmio_valid: got %b/%b want 1/0", mmio_valid, err); end
        mem_read = 1;
        #1;
        checks++;
        if (stall !== 1'b0 || rdata !== 32'h1234_5678) begin failures++; $display("FAIL mmio_load: got %b/%h want 0/12345678", stall, rdata); end
        tick;
        idle;
        checks++;
        if (mmio_valid !== 1'b0) begin failures++; $display("FAIL mmio_pulse: got %b want 0", mmio_valid); end
        do_store(32'hFFFF_FFF0, 32'h0, 4'b0011, 1'b1, "mmio_partial");
        checks++;
        if (mmio_out !== 32'h1234_5678) begin failures++; $display("FAIL mmio_partial_hold: got %h want 12345678", mmio_out); end
        do_load(32'h0000_0FF0, 1'b0, "mmio_no_ram");
        idle;
    endtask
`endif

    task automatic test_reset_mid_load;
        addr = 32'h10; mem_read = 1;
        tick;
        #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL midrst_wait_stall: got %b want 1", stall); end
        reset = 0;
        #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL midrst_stall: got %b want 0", stall); end
        checks++;
        if (rdata !== 32'h0) begin failures++; $display("FAIL midrst_rdata: got %h want 0", rdata); end
        idle;
        @(negedge clk) reset = 1;
        tick;
        do_load(32'h10, 1'b0, "after_reset");
        idle;
    endtask

    task automatic test_random;
        logic [31:0] a;
        for (int n = 0; n < 200; n++) begin
            bit oor;
            oor = ($urandom_range(0, 9) == 0);
            a = oor ? ({$urandom_range(DEPTH, 32'h3FFF_0000), 2'b00}) : (32'($urandom_range(0, 63)) << 2);
            if ($urandom_range(0, 1) == 0)
                do_store(a, $urandom, 4'($urandom_range(0, 15)), oor, "rand_store");
            else
                do_load(a | 32'($urandom_range(0, 3)), oor, "rand_load");
            if ($urandom_range(0, 2) == 0) begin idle; tick; end
        end
        idle;
    endtask

    initial begin
        test_reset;
        test_fill;
        test_store_load;
        test_back_to_back;
        test_conflict;
        test_range;
`ifdef DMEM_MMIO_EN
        test_mmio;
`endif
        test_reset_mid_load;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
